color_run_detector: RTL and testbench
=====================================

Name: color_run_detector

Overview:
- Parametrised successor to the per-pixel colour classifier: classifies a streamed HSV pixel into one of NUM_CLASSES hue classes, BLACK or VOID.
- Tracks horizontal runs of one class along a scanline and bridges short black gaps (specular/shadow holes on the ball).
- Emits one descriptor per qualifying run: class, start x, end x, length.
- Sits between the HSV converter and the ball-position accumulator.

Parameters:
- NUM_CLASSES, 3, number of hue classes (1..8)
- CLS_W, 3, class-id width
- SAT_W, 5, saturation width
- VAL_W, 5, value width
- X_W, 10, horizontal coordinate width
- HUE_LO, {9'd190,9'd40,9'd340}, packed 9-bit lower hue bound per class; class 0 in the LSBs
- HUE_HI, {9'd250,9'd70,9'd20}, packed 9-bit upper hue bound per class; bounds are inclusive; LO>HI means wrap through 0
- MIN_SAT, 8, saturation threshold for a colour class (>=)
- MIN_VAL, 8, value threshold for a colour class (>=)
- BLACK_VAL, 4, pixel is BLACK if not coloured and val < BLACK_VAL
- MAX_GAP, 2, maximum consecutive BLACK pixels bridged inside a run
- MIN_RUN, 4, minimum run length reported

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- pix_valid  in  1  pixel qualifier
- line_start  in  1  first pixel of a new scanline (may coincide with pix_valid)
- hue  in  9  hue 0..359
- sat  in  SAT_W  saturation
- val  in  VAL_W  value
- horiz_count  in  X_W  pixel x coordinate
- run_valid  out  1  one-cycle descriptor strobe
- run_class  out  CLS_W  class of reported run
- run_start  out  X_W  first coloured x
- run_end  out  X_W  last coloured x
- run_len  out  X_W+1  run_end-run_start+1

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, gap counter 0, all outputs 0. Any open run is discarded, never emitted.
- Stage 1 (registered on pix_valid): pixel class.
  - Coloured when sat>=MIN_SAT and val>=MIN_VAL and hue matches a class range; the lowest-index class wins on overlap.
  - Otherwise BLACK when val<BLACK_VAL, else VOID.
  - hue>=360 is VOID.
- Stage 2 FSM, advancing only on a classified pixel. States: IDLE, RUN, GAP.
  - IDLE:
    - colour k -> RUN; cls=k, start=end=x.
    - BLACK or VOID -> stay IDLE.
  - RUN:
    - same class -> end=x.
    - BLACK -> GAP; gap=1.
    - VOID -> close run, go IDLE.
    - other colour -> close run and open a new run on this pixel in the same cycle.
  - GAP:
    - same class -> RUN; end=x.
    - BLACK -> gap+1; when gap would exceed MAX_GAP, close run, go IDLE.
    - VOID -> close run, go IDLE.
    - other colour -> close run and open a new run.
  - end never includes gap pixels.
- Close: if end-start+1 >= MIN_RUN, assert run_valid for exactly one cycle with descriptor fields. Otherwise the run is silently dropped.
- Latency: run_valid rises 2 cycles after the input pixel that triggers the close.
- Descriptor outputs hold their last value between strobes.
- line_start:
  - Closes any open run, using the end of the previous line, before processing the coincident pixel.
  - That pixel is then treated from IDLE.
  - Runs never span lines.
  - line_start without pix_valid only closes.
- pix_valid low: no state change; gaps count pixels, not cycles.
- Back-to-back closes on consecutive pixels produce strobes on consecutive cycles; no stall and no backpressure.

Decomposition:
- Package color_pkg: pixel-class enum (VOID, BLACK, COLOUR), FSM state enum, and hue-range helper function (inclusive, wrap-aware).
- Sub-module hsv_class_lut: combinational + output-registered classifier (stage 1), parametrised like the parent.
- Run FSM and descriptor registers live in the top module.

Test Plan:
- Assert rst_n low 3 cycles during blue run x=100..120, release, then send void pixels -> run_valid never asserts.
- Wrap red: hue 350 at x=10..19, hue 10 at x=20..24, VOID at x=25 -> one strobe with class 0, start 10, end 24, len 15, exactly 2 cycles after the x=25 pixel.
- Gap bridging: blue 100..104, BLACK 105..106, blue 107..110, VOID 111 -> single strobe with class 2, start 100, end 110, len 11.
- Gap overflow: BLACK at 105..107 instead, blue 108..110, VOID 111 -> strobe for start 100, end 104 only; 108..110 is len 3 and is suppressed.
- Back-to-back: yellow 0..5, blue 6..12, then line_start with pix_valid -> two strobes on consecutive cycles: (1,0,5,6) then (2,6,12,7).
- line_start mid-run: blue 600..639, then line_start with blue at x=0..4, then VOID -> strobes (2,600,639,40) then (2,0,4,5).

Source files
------------

// File: rtl/color_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : color_pkg                                                 |
// | Brief    : Shared types and the hue-range helper for run detection.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package color_pkg;

  localparam int HUE_W    = 9;
  localparam int HUE_SPAN = 360;

  typedef enum logic [1:0] {
    PIX_VOID   = 2'd0,
    PIX_BLACK  = 2'd1,
    PIX_COLOUR = 2'd2
  } pix_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } run_state_e;

  // Inclusive bounds; lo > hi describes a range that wraps through hue 0.
  function automatic logic hue_in_range(input logic [HUE_W-1:0] h,
                                         input logic [HUE_W-1:0] lo,
                                         input logic [HUE_W-1:0] hi);
    if (lo <= hi) return (h >= lo) && (h <= hi);
    else          return (h >= lo) || (h <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_class_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hsv_class_lut                                             |
// | Brief    : Classifies one HSV pixel as hue class, BLACK or VOID.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hsv_class_lut
  import color_pkg::*;
#(
  parameter int NUM_CLASSES = 3,
  parameter int CLS_W       = 3,
  parameter int SAT_W       = 5,
  parameter int VAL_W       = 5,
  parameter int X_W         = 10,
  parameter logic [9*NUM_CLASSES-1:0] HUE_LO = {9'd190, 9'd40, 9'd340},
  parameter logic [9*NUM_CLASSES-1:0] HUE_HI = {9'd250, 9'd70, 9'd20},
  parameter int MIN_SAT     = 8,
  parameter int MIN_VAL     = 8,
  parameter int BLACK_VAL   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             line_start,
  input  logic [8:0]       hue,
  input  logic [SAT_W-1:0] sat,
  input  logic [VAL_W-1:0] val,
  input  logic [X_W-1:0]   horiz_count,
  output logic             cls_valid,
  output logic             cls_line_start,
  output pix_kind_e        cls_kind,
  output logic [CLS_W-1:0] cls_id,
  output logic [X_W-1:0]   cls_x
);

  localparam logic [SAT_W-1:0] C_MIN_SAT   = SAT_W'(MIN_SAT);
  localparam logic [VAL_W-1:0] C_MIN_VAL   = VAL_W'(MIN_VAL);
  localparam logic [VAL_W-1:0] C_BLACK_VAL = VAL_W'(BLACK_VAL);
  localparam logic [8:0]       C_HUE_SPAN  = 9'(HUE_SPAN);

  logic             w_hue_ok;
  logic             w_hit;
  logic [CLS_W-1:0] w_id;
  pix_kind_e        w_kind;

  always_comb begin
    w_hue_ok = (hue < C_HUE_SPAN);
    w_hit    = 1'b0;
    w_id     = '0;
    if (w_hue_ok && (sat >= C_MIN_SAT) && (val >= C_MIN_VAL)) begin
      // Scan downwards so the lowest matching class index is the one kept.
      for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
        if (hue_in_range(hue, HUE_LO[9*i +: 9], HUE_HI[9*i +: 9])) begin
          w_hit = 1'b1;
          w_id  = CLS_W'(i);
        end
      end
    end
    if (w_hit)                                 w_kind = PIX_COLOUR;
    else if (w_hue_ok && (val < C_BLACK_VAL)) w_kind = PIX_BLACK;
    else                                       w_kind = PIX_VOID;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cls_valid      <= 1'b0;
      cls_line_start <= 1'b0;
      cls_kind       <= PIX_VOID;
      cls_id         <= '0;
      cls_x          <= '0;
    end else begin
      cls_valid      <= pix_valid;
      cls_line_start <= line_start;
      if (pix_valid) begin
        cls_kind <= w_kind;
        cls_id   <= w_id;
        cls_x    <= horiz_count;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/color_run_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : color_run_detector                                        |
// | Brief    : Per-scanline colour run tracker with black-gap bridging.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module color_run_detector
  import color_pkg::*;
#(
  parameter int NUM_CLASSES = 3,
  parameter int CLS_W       = 3,
  parameter int SAT_W       = 5,
  parameter int VAL_W       = 5,
  parameter int X_W         = 10,
  parameter logic [9*NUM_CLASSES-1:0] HUE_LO = {9'd190, 9'd40, 9'd340},
  parameter logic [9*NUM_CLASSES-1:0] HUE_HI = {9'd250, 9'd70, 9'd20},
  parameter int MIN_SAT     = 8,
  parameter int MIN_VAL     = 8,
  parameter int BLACK_VAL   = 4,
  parameter int MAX_GAP     = 2,
  parameter int MIN_RUN     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             line_start,
  input  logic [8:0]       hue,
  input  logic [SAT_W-1:0] sat,
  input  logic [VAL_W-1:0] val,
  input  logic [X_W-1:0]   horiz_count,
  output logic             run_valid,
  output logic [CLS_W-1:0] run_class,
  output logic [X_W-1:0]   run_start,
  output logic [X_W-1:0]   run_end,
  output logic [X_W:0]     run_len
);

  localparam int           GAP_W     = $clog2(MAX_GAP + 2);
  localparam logic [X_W:0] C_MIN_RUN = (X_W+1)'(MIN_RUN);
  localparam logic [X_W:0] C_ONE     = (X_W+1)'(1);

  logic             w_s1_valid;
  logic             w_s1_line_start;
  pix_kind_e        w_s1_kind;
  logic [CLS_W-1:0] w_s1_cls;
  logic [X_W-1:0]   w_s1_x;

  run_state_e       r_state;
  logic [GAP_W-1:0] r_gap;
  logic [CLS_W-1:0] r_cls;
  logic [X_W-1:0]   r_start;
  logic [X_W-1:0]   r_end;

  logic             w_close;
  logic             w_from_idle;
  logic [X_W:0]     w_len;

  hsv_class_lut #(
    .NUM_CLASSES (NUM_CLASSES),
    .CLS_W       (CLS_W),
    .SAT_W       (SAT_W),
    .VAL_W       (VAL_W),
    .X_W         (X_W),
    .HUE_LO      (HUE_LO),
    .HUE_HI      (HUE_HI),
    .MIN_SAT     (MIN_SAT),
    .MIN_VAL     (MIN_VAL),
    .BLACK_VAL   (BLACK_VAL)
  ) u_lut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix_valid      (pix_valid),
    .line_start     (line_start),
    .hue            (hue),
    .sat            (sat),
    .val            (val),
    .horiz_count    (horiz_count),
    .cls_valid      (w_s1_valid),
    .cls_line_start (w_s1_line_start),
    .cls_kind       (w_s1_kind),
    .cls_id         (w_s1_cls),
    .cls_x          (w_s1_x)
  );

  always_comb begin
    w_len   = {1'b0, r_end} - {1'b0, r_start} + C_ONE;
    w_close = 1'b0;
    if (r_state != ST_IDLE) begin
      if (w_s1_line_start) begin
        w_close = 1'b1;
      end else if (w_s1_valid) begin
        if (w_s1_kind == PIX_VOID)
          w_close = 1'b1;
        else if (w_s1_kind == PIX_BLACK)
          w_close = (r_state == ST_GAP) ? (int'(r_gap) + 1 > MAX_GAP) : (1 > MAX_GAP);
        else
          w_close = (w_s1_cls != r_cls);
      end
    end
    // After a close the same pixel is judged as if no run were open.
    w_from_idle = (r_state == ST_IDLE) || w_s1_line_start || w_close;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gap     <= '0;
      r_cls     <= '0;
      r_start   <= '0;
      r_end     <= '0;
      run_valid <= 1'b0;
      run_class <= '0;
      run_start <= '0;
      run_end   <= '0;
      run_len   <= '0;
    end else begin
      run_valid <= 1'b0;
      if (w_close && (w_len >= C_MIN_RUN)) begin
        run_valid <= 1'b1;
        run_class <= r_cls;
        run_start <= r_start;
        run_end   <= r_end;
        run_len   <= w_len;
      end
      if (w_s1_valid) begin
        if (w_from_idle) begin
          r_gap <= '0;
          if (w_s1_kind == PIX_COLOUR) begin
            r_state <= ST_RUN;
            r_cls   <= w_s1_cls;
            r_start <= w_s1_x;
            r_end   <= w_s1_x;
          end else begin
            r_state <= ST_IDLE;
          end
        end else if (w_s1_kind == PIX_COLOUR) begin
          r_state <= ST_RUN;
          r_end   <= w_s1_x;
          r_gap   <= '0;
        end else begin
          r_state <= ST_GAP;
          r_gap   <= r_gap + 1'b1;
        end
      end else if (w_close) begin
        r_state <= ST_IDLE;
        r_gap   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_run_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_color_run_detector                                     |
// | Brief    : Randomised bench against a behavioural run model.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_color_run_detector;

  localparam int NCYC    = 8192;
  localparam int MAX_GAP = 2;
  localparam int MIN_RUN = 4;

  logic       clk = 1'b1;
  logic       rst_n = 1'b0, pix_valid = 1'b0, line_start = 1'b0;
  logic [8:0] hue = '0;
  logic [4:0] sat = '0, val = '0;
  logic [9:0] horiz_count = '0;
  logic       run_valid;
  logic [2:0] run_class;
  logic [9:0] run_start, run_end;
  logic [10:0] run_len;

  always #5 clk = ~clk;

  color_run_detector dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .line_start(line_start),
    .hue(hue), .sat(sat), .val(val), .horiz_count(horiz_count),
    .run_valid(run_valid), .run_class(run_class), .run_start(run_start),
    .run_end(run_end), .run_len(run_len)
  );

  typedef struct {int cls; int s; int e; int l; int t;} rec_t;
  rec_t log_q[$];

  int total = 0, bad = 0, cyc_in = 0, k = 0;
  bit sv[NCYC];
  bit rm[NCYC];
  int scls[NCYC], ss[NCYC], se[NCYC], sl[NCYC];
  int lo[3] = '{340, 40, 190};
  int hi[3] = '{20, 70, 250};

  bit m_open = 0;
  int m_cls = 0, m_s = 0, m_e = 0, m_blk = 0;

  // Class >= 0, -1 for BLACK, -2 for VOID.
  function automatic int classify(int h, int s, int v);
    if (h >= 360) return -2;
    if (s >= 8 && v >= 8)
      for (int c = 0; c < 3; c++)
        if ((lo[c] <= hi[c]) ? (h >= lo[c] && h <= hi[c]) : (h >= lo[c] || h <= hi[c]))
          return c;
    if (v < 4) return -1;
    return -2;
  endfunction

  task automatic m_close(int t);
    int len;
    len = m_e - m_s + 1;
    m_open = 0;
    if (len >= MIN_RUN) begin
      sv[t+1] = 1; scls[t+1] = m_cls; ss[t+1] = m_s; se[t+1] = m_e; sl[t+1] = len;
      log_q.push_back('{m_cls, m_s, m_e, len, t});
    end
  endtask

  task automatic model(bit r, bit pv, bit ls, int h, int s, int v, int x, int t);
    int c;
    if (!r) begin
      rm[t] = 1; m_open = 0; m_blk = 0;
    end else begin
      if (ls && m_open) m_close(t);
      if (pv) begin
        c = classify(h, s, v);
        if (m_open && c != m_cls) begin
          if (c == -1) begin
            m_blk++;
            if (m_blk > MAX_GAP) m_close(t);
          end else begin
            m_close(t);
          end
        end else if (m_open) begin
          m_e = x; m_blk = 0;
        end
        if (!m_open && c >= 0) begin
          m_open = 1; m_cls = c; m_s = x; m_e = x; m_blk = 0;
        end
      end
    end
  endtask

  task automatic drive(bit r, bit pv, bit ls, int h, int s, int v, int x);
    @(negedge clk);
    rst_n = r; pix_valid = pv; line_start = ls;
    hue = 9'(h); sat = 5'(s); val = 5'(v); horiz_count = 10'(x);
    model(r, pv, ls, h, s, v, x, cyc_in);
    cyc_in++;
  endtask

  task automatic col(int h, int x);      drive(1, 1, 0, h, 20, 20, x); endtask
  task automatic blk(int x);             drive(1, 1, 0, 100, 0, 2, x); endtask
  task automatic vd(int x);              drive(1, 1, 0, 100, 0, 20, x); endtask

  task automatic chk_n(string name, int n);
    total++;
    if (log_q.size() != n) begin
      bad++;
      $display("FAIL %s: strobe count got %0d want %0d", name, log_q.size(), n);
    end
  endtask

  task automatic chk_rec(string name, int i, int c, int s, int e, int l, int t);
    total++;
    if (log_q.size() <= i) begin
      bad++;
      $display("FAIL %s: record %0d missing, want (%0d,%0d,%0d,%0d)", name, i, c, s, e, l);
    end else if (log_q[i].cls != c || log_q[i].s != s || log_q[i].e != e ||
                 log_q[i].l != l || (t >= 0 && log_q[i].t != t)) begin
      bad++;
      $display("FAIL %s: got (%0d,%0d,%0d,%0d @%0d) want (%0d,%0d,%0d,%0d @%0d)", name,
               log_q[i].cls, log_q[i].s, log_q[i].e, log_q[i].l, log_q[i].t, c, s, e, l, t);
    end
  endtask

  // Per-cycle compare of every DUT output against the model's strobe schedule.
  int h_c = 0, h_s = 0, h_e = 0, h_l = 0;
  always @(posedge clk) begin
    int ev;
    #1;
    if (k < NCYC) begin
      ev = 0;
      if (rm[k]) begin
        h_c = 0; h_s = 0; h_e = 0; h_l = 0;
      end else if (sv[k]) begin
        ev = 1; h_c = scls[k]; h_s = ss[k]; h_e = se[k]; h_l = sl[k];
      end
      total++;
      if (run_valid !== 1'(ev) || run_class !== 3'(h_c) || run_start !== 10'(h_s) ||
          run_end !== 10'(h_e) || run_len !== 11'(h_l)) begin
        bad++;
        $display("FAIL out@%0d: got v=%0b c=%0d s=%0d e=%0d l=%0d want v=%0d c=%0d s=%0d e=%0d l=%0d",
                 k, run_valid, run_class, run_start, run_end, run_len, ev, h_c, h_s, h_e, h_l);
      end
    end
    k++;
  end

  initial begin
    int t_mark, t_mark2;
    int x, kind;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);

    // Reset during an open blue run discards it.
    log_q.delete();
    for (int i = 100; i <= 110; i++) col(220, i);
    for (int i = 111; i <= 113; i++) drive(0, 1, 0, 220, 20, 20, i);
    for (int i = 114; i <= 120; i++) vd(i);
    chk_n("reset_discard", 0);

    // Red wrapping through hue 0.
    vd(0); log_q.delete();
    for (int i = 10; i <= 19; i++) col(350, i);
    for (int i = 20; i <= 24; i++) col(10, i);
    t_mark = cyc_in; vd(25);
    chk_n("wrap_red_n", 1);
    chk_rec("wrap_red", 0, 0, 10, 24, 15, t_mark);

    // Two-pixel black gap is bridged.
    vd(0); log_q.delete();
    for (int i = 100; i <= 104; i++) col(220, i);
    blk(105); blk(106);
    for (int i = 107; i <= 110; i++) col(220, i);
    vd(111);
    chk_n("gap_bridge_n", 1);
    chk_rec("gap_bridge", 0, 2, 100, 110, 11, -1);

    // Three-pixel gap closes; the short tail is suppressed.
    vd(0); log_q.delete();
    for (int i = 100; i <= 104; i++) col(220, i);
    blk(105); blk(106); t_mark = cyc_in; blk(107);
    for (int i = 108; i <= 110; i++) col(220, i);
    vd(111);
    chk_n("gap_over_n", 1);
    chk_rec("gap_over", 0, 2, 100, 104, 5, t_mark);

    // Colour change then line_start closes both runs.
    vd(0); log_q.delete();
    for (int i = 0; i <= 5; i++) col(55, i);
    t_mark = cyc_in;
    for (int i = 6; i <= 12; i++) col(220, i);
    t_mark2 = cyc_in; drive(1, 1, 1, 220, 20, 20, 0); vd(1);
    chk_n("b2b_n", 2);
    chk_rec("b2b_yellow", 0, 1, 0, 5, 6, t_mark);
    chk_rec("b2b_blue", 1, 2, 6, 12, 7, t_mark2);

    // line_start mid-run, new run on the next line.
    vd(0); log_q.delete();
    for (int i = 600; i <= 639; i++) col(220, i);
    drive(1, 1, 1, 220, 20, 20, 0);
    for (int i = 1; i <= 4; i++) col(220, i);
    vd(5);
    chk_n("line_n", 2);
    chk_rec("line_prev", 0, 2, 600, 639, 40, -1);
    chk_rec("line_next", 1, 2, 0, 4, 5, -1);

    // line_start without a pixel only closes.
    vd(0); log_q.delete();
    for (int i = 20; i <= 27; i++) col(55, i);
    drive(1, 0, 1, 0, 0, 0, 0);
    col(55, 0);
    vd(1);
    chk_n("ls_only_n", 1);
    chk_rec("ls_only", 0, 1, 20, 27, 8, -1);

    // Random stream with sticky pixel kinds so runs form.
    x = 0; kind = 4;
    for (int i = 0; i < 3000; i++) begin
      int r, h, s, v;
      bit ls, pv;
      r = $urandom_range(0, 999);
      if (r < 4) begin
        drive(0, 1'($urandom_range(0, 1)), 0, 220, 20, 20, x);
      end else begin
        ls = (r < 25) || (x > 1000);
        pv = ($urandom_range(0, 3) != 0);
        if (ls) x = 0;
        if ($urandom_range(0, 5) == 0) kind = $urandom_range(0, 5);
        s = $urandom_range(8, 31); v = $urandom_range(8, 31);
        case (kind)
          0: h = ($urandom_range(0, 1) != 0) ? $urandom_range(340, 359) : $urandom_range(0, 20);
          1: h = $urandom_range(40, 70);
          2: h = $urandom_range(190, 250);
          3: begin h = $urandom_range(0, 359); s = $urandom_range(0, 7); v = $urandom_range(0, 3); end
          4: begin h = $urandom_range(0, 359); s = $urandom_range(0, 7); v = $urandom_range(4, 31); end
          default: begin h = $urandom_range(0, 511); s = $urandom_range(0, 31); v = $urandom_range(0, 31); end
        endcase
        drive(1, pv, ls, h, s, v, x);
        if (pv) x++;
      end
    end

    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
